// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state codes and
// default sizing constants, also used by top-level bench monitors.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam int MEM_TIMEOUT_DEFAULT = 15;
   localparam int CNT_W_DEFAULT       = 16;

endpackage

// File: rtl/cpu_sequencer_retire.sv
// Retired-instruction counter: saturating up-counter with synchronous clear.
module seq_retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/writeback sequencing, datapath
// enables, halt/error status and the retired-instruction count.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             start,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_branch,
   input  logic             branch_taken,
   input  logic             is_halt,
   input  logic             writes_reg,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             halt,
   output logic             error,
   output logic [CNT_W-1:0] inst_count,
   output logic [2:0]       state
);

   // Last wait-count value before the timeout fires on a further not-ready cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_reg, state_next;
   logic [7:0] wait_reg, wait_next;
   logic       halt_reg, halt_next;
   logic       error_reg, error_next;

   logic ir_load_c, pc_inc_c, pc_load_c, reg_write_c, mem_read_c, mem_write_c;
   logic halt_retire;
   logic illegal_class;

   assign illegal_class = (is_load & is_store) |
                          (is_halt & (is_load | is_store | is_branch));

   always_ff @(posedge CLK) begin
      if (start) begin
         state_reg <= ST_FETCH;
         wait_reg  <= 8'd0;
         halt_reg  <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
         halt_reg  <= halt_next;
         error_reg <= error_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      wait_next   = 8'd0;
      halt_next   = halt_reg;
      error_next  = error_reg;
      ir_load_c   = 1'b0;
      pc_inc_c    = 1'b0;
      pc_load_c   = 1'b0;
      reg_write_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      halt_retire = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            ir_load_c  = 1'b1;
            state_next = ST_DECODE;
         end
         ST_DECODE: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            if (illegal_class) begin
               state_next = ST_HALT;
               halt_next  = 1'b1;
               error_next = 1'b1;
            end else if (is_halt) begin
               state_next  = ST_HALT;
               halt_next   = 1'b1;
               halt_retire = 1'b1;
            end else if (is_branch) begin
               pc_load_c  = branch_taken;
               pc_inc_c   = ~branch_taken;
               state_next = ST_FETCH;
            end else if (is_load | is_store) begin
               state_next = ST_MEM;
            end else begin
               state_next = ST_WB;
            end
         end
         ST_MEM: begin
            mem_read_c  = is_load;
            mem_write_c = is_store & ~is_load;
            if (mem_ready) begin
               if (is_load) begin
                  state_next = ST_WB;
               end else begin
                  pc_inc_c   = 1'b1;
                  state_next = ST_FETCH;
               end
            end else if (wait_reg == TIMEOUT_LAST) begin
               state_next = ST_HALT;
               halt_next  = 1'b1;
               error_next = 1'b1;
            end else begin
               wait_next = wait_reg + 8'd1;
            end
         end
         ST_WB: begin
            reg_write_c = writes_reg;
            pc_inc_c    = 1'b1;
            state_next  = ST_FETCH;
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_HALT;
            halt_next  = 1'b1;
            error_next = 1'b1;
         end
      endcase
   end

   // Reset wins over everything, so all enables are masked while it is held.
   assign ir_load   = ir_load_c   & ~start;
   assign pc_inc    = pc_inc_c    & ~start;
   assign pc_load   = pc_load_c   & ~start;
   assign reg_write = reg_write_c & ~start;
   assign mem_read  = mem_read_c  & ~start;
   assign mem_write = mem_write_c & ~start;
   assign halt      = halt_reg;
   assign error     = error_reg;
   assign state     = state_reg;

   seq_retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire (
      .clk   (CLK),
      .clr   (start),
      .inc   (pc_inc | pc_load | (halt_retire & ~start)),
      .count (inst_count)
   );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: cycle vector table, hand-written corner
// sequences and randomized instructions checked against per-instruction rules.
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   localparam int CW = 4;
   localparam int TO = 15;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic CLK = 1'b0;
   logic start, is_load, is_store, is_branch, branch_taken, is_halt, writes_reg, mem_ready;
   logic ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write, halt, error;
   logic [CW-1:0] inst_count;
   logic [2:0]    state;

   cpu_sequencer #(
      .MEM_TIMEOUT (TO),
      .CNT_W       (CW)
   ) dut (
      .CLK          (CLK),
      .start        (start),
      .is_load      (is_load),
      .is_store     (is_store),
      .is_branch    (is_branch),
      .branch_taken (branch_taken),
      .is_halt      (is_halt),
      .writes_reg   (writes_reg),
      .mem_ready    (mem_ready),
      .ir_load      (ir_load),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .reg_write    (reg_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .halt         (halt),
      .error        (error),
      .inst_count   (inst_count),
      .state        (state)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int model_cnt = 0;

   // Input bits: {start, is_load, is_store, is_branch, branch_taken, is_halt, writes_reg, mem_ready}
   // Output bits: {ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write, halt, error}
   typedef struct {
      logic [7:0]    in_bits;
      logic [2:0]    exp_state;
      logic [7:0]    exp_outs;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [7:0] b);
      {start, is_load, is_store, is_branch, branch_taken, is_halt, writes_reg, mem_ready} = b;
   endtask

   function automatic logic [7:0] outs();
      return {ir_load, pc_inc, pc_load, reg_write, mem_read, mem_write, halt, error};
   endfunction

   task automatic do_reset();
      drive(8'b1000_0000);
      step();
      drive(8'b0000_0000);
      model_cnt = 0;
   endtask

   // One instruction; cls 0=ALU 1=branch 2=load 3=store, w = not-ready MEM cycles.
   task automatic run_instr(input int cls, input logic wr, input logic tk, input int w);
      int lat, n_ir, n_inc, n_ld, n_rw, n_mr, n_mw, n_clash;
      logic ld, sto, br, rdy;
      ld  = (cls == 2);
      sto = (cls == 3);
      br  = (cls == 1);
      case (cls)
         0: lat = 4;
         1: lat = 3;
         2: lat = 5 + w;
         default: lat = 4 + w;
      endcase
      n_ir = 0; n_inc = 0; n_ld = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_clash = 0;
      for (int k = 0; k < lat; k++) begin
         if (cls >= 2 && k >= 3) rdy = (k >= 3 + w);
         else rdy = 1'($urandom_range(0, 1));
         drive({1'b0, ld, sto, br, tk, 1'b0, wr, rdy});
         #1;
         if (k == 0) check("first_cycle_ir_load", 32'(ir_load), 32'd1);
         n_ir  += int'(ir_load);
         n_inc += int'(pc_inc);
         n_ld  += int'(pc_load);
         n_rw  += int'(reg_write);
         n_mr  += int'(mem_read);
         n_mw  += int'(mem_write);
         if ((pc_inc && pc_load) || (mem_read && mem_write)) n_clash++;
         step();
      end
      #1;
      if (model_cnt < CNT_MAX) model_cnt++;
      check("instr_end_state", 32'(state), 32'(ST_FETCH));
      check("ir_load_cycles", 32'(n_ir), 32'd1);
      check("pc_inc_cycles", 32'(n_inc), (cls == 1) ? 32'(!tk) : 32'd1);
      check("pc_load_cycles", 32'(n_ld), (cls == 1) ? 32'(tk) : 32'd0);
      check("reg_write_cycles", 32'(n_rw), (cls == 0 || cls == 2) ? 32'(wr) : 32'd0);
      check("mem_read_cycles", 32'(n_mr), (cls == 2) ? 32'(w + 1) : 32'd0);
      check("mem_write_cycles", 32'(n_mw), (cls == 3) ? 32'(w + 1) : 32'd0);
      check("exclusive_enables", 32'(n_clash), 32'd0);
      check("inst_count", 32'(inst_count), 32'(model_cnt));
      $display("instr class=%0d wr=%0b tk=%0b w=%0d cycles=%0d count=%0d", cls, wr, tk, w, lat, inst_count);
   endtask

   initial begin
      int n_en, n_mw;

      vecs[0]  = '{8'b1000_0000, 3'd0, 8'b0000_0000, 4'd0};
      vecs[1]  = '{8'b0000_0010, 3'd0, 8'b1000_0000, 4'd0};
      vecs[2]  = '{8'b0000_0011, 3'd1, 8'b0000_0000, 4'd0};
      vecs[3]  = '{8'b0000_0011, 3'd2, 8'b0000_0000, 4'd0};
      vecs[4]  = '{8'b0000_0010, 3'd4, 8'b0101_0000, 4'd0};
      vecs[5]  = '{8'b0001_1000, 3'd0, 8'b1000_0000, 4'd1};
      vecs[6]  = '{8'b0001_1000, 3'd1, 8'b0000_0000, 4'd1};
      vecs[7]  = '{8'b0001_1000, 3'd2, 8'b0010_0000, 4'd1};
      vecs[8]  = '{8'b0001_0000, 3'd0, 8'b1000_0000, 4'd2};
      vecs[9]  = '{8'b0001_0000, 3'd1, 8'b0000_0000, 4'd2};
      vecs[10] = '{8'b0001_0000, 3'd2, 8'b0100_0000, 4'd2};
      vecs[11] = '{8'b0100_0010, 3'd0, 8'b1000_0000, 4'd3};
      vecs[12] = '{8'b0100_0011, 3'd1, 8'b0000_0000, 4'd3};
      vecs[13] = '{8'b0100_0011, 3'd2, 8'b0000_0000, 4'd3};
      vecs[14] = '{8'b0100_0010, 3'd3, 8'b0000_1000, 4'd3};
      vecs[15] = '{8'b0100_0010, 3'd3, 8'b0000_1000, 4'd3};
      vecs[16] = '{8'b0100_0010, 3'd3, 8'b0000_1000, 4'd3};
      vecs[17] = '{8'b0100_0011, 3'd3, 8'b0000_1000, 4'd3};
      vecs[18] = '{8'b0100_0010, 3'd4, 8'b0101_0000, 4'd3};
      vecs[19] = '{8'b0000_0000, 3'd0, 8'b1000_0000, 4'd4};

      drive(8'b1000_0000);
      step();
      step();

      // Cycle table: reset, ALU, taken/not-taken branch, load with 3 waits.
      foreach (vecs[i]) begin
         drive(vecs[i].in_bits);
         #1;
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_outs));
         check($sformatf("vec%0d_count", i), 32'(inst_count), 32'(vecs[i].exp_cnt));
         $display("vec %0d in=%b state=%0d outs=%b count=%0d", i, vecs[i].in_bits, state, outs(), inst_count);
         step();
      end

      // Store that never completes: timeout halt with error, count unchanged.
      do_reset();
      run_instr(0, 1'b1, 1'b0, 0);
      drive(8'b0010_0000);
      step(); step(); step();
      n_mw = 0;
      for (int k = 0; k < TO; k++) begin
         #1;
         n_mw += int'(mem_write);
         step();
      end
      #1;
      check("timeout_mem_write_cycles", 32'(n_mw), 32'(TO));
      check("timeout_state", 32'(state), 32'(ST_HALT));
      check("timeout_halt_error", 32'({halt, error}), 32'b11);
      check("timeout_request_dropped", 32'(mem_write), 32'd0);
      check("timeout_count", 32'(inst_count), 32'd1);
      $display("store timeout: mem_write cycles=%0d halt=%0b error=%0b", n_mw, halt, error);

      // Illegal class combinations halt with error and retire nothing.
      do_reset();
      run_instr(0, 1'b0, 1'b0, 0);
      drive(8'b0110_0000);
      step(); step(); step();
      check("ld_st_error", 32'({state, halt, error}), 32'({ST_HALT, 2'b11}));
      check("ld_st_count", 32'(inst_count), 32'd1);
      do_reset();
      drive(8'b0001_0100);
      step(); step(); step();
      check("halt_br_error", 32'({state, halt, error}), 32'({ST_HALT, 2'b11}));
      check("halt_br_count", 32'(inst_count), 32'd0);

      // Halt after five instructions, then 20 idle cycles with noisy inputs.
      do_reset();
      for (int i = 0; i < 5; i++) run_instr(0, 1'(i % 2), 1'b0, 0);
      drive(8'b0000_0100);
      step(); step();
      check("halt_not_yet", 32'(halt), 32'd0);
      step();
      check("halt_entry", 32'({state, halt, error}), 32'({ST_HALT, 2'b10}));
      check("halt_count", 32'(inst_count), 32'd6);
      n_en = 0;
      for (int k = 0; k < 20; k++) begin
         drive({1'b0, 7'($urandom)});
         #1;
         if (outs()[7:2] != 6'd0) n_en++;
         step();
      end
      check("halt_no_enables", 32'(n_en), 32'd0);
      check("halt_held", 32'({state, halt, error}), 32'({ST_HALT, 2'b10}));
      check("halt_count_held", 32'(inst_count), 32'd6);
      $display("halt: count=%0d enable cycles=%0d", inst_count, n_en);

      // Reset while halted.
      drive({1'b1, 7'($urandom)});
      #1;
      check("reset_masks_enables", 32'(outs()[7:2]), 32'd0);
      step();
      drive(8'b0000_0000);
      #1;
      check("reset_from_halt", 32'({state, halt, error}), 32'({ST_FETCH, 2'b00}));
      check("reset_from_halt_count", 32'(inst_count), 32'd0);

      // Reset in the middle of a MEM wait.
      model_cnt = 0;
      run_instr(0, 1'b1, 1'b0, 0);
      drive(8'b0100_0010);
      step(); step(); step();
      check("mid_mem_read", 32'(mem_read), 32'd1);
      step(); step();
      drive(8'b1100_0010);
      #1;
      check("mid_mem_read_drop", 32'(mem_read), 32'd0);
      step();
      drive(8'b0000_0000);
      #1;
      check("mid_mem_reset_state", 32'({state, halt, error}), 32'({ST_FETCH, 2'b00}));
      check("mid_mem_reset_count", 32'(inst_count), 32'd0);
      $display("mid-MEM reset: state=%0d count=%0d", state, inst_count);

      // Random instruction stream; count saturates at CNT_MAX.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         run_instr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
